// File: rtl/hit_judge.sv
// hit_judge: bullet/enemy collision judge and enemy life-cycle controller.
// Samples the bullet/enemy rectangle overlap once per frame, pulses boom on a
// hit, runs the ALIVE -> EXPLODE -> DEAD -> ALIVE sequence and keeps a
// saturating 4-digit BCD score for the HUD.
module hit_judge #(
  parameter int BW             = 4,
  parameter int BH             = 40,
  parameter int EW             = 48,
  parameter int EH             = 48,
  parameter int STEP_FRAMES    = 6,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        b_valid,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  e_x,
  input  logic [9:0]  e_y,
  output logic        boom,
  output logic        enemy_alive,
  output logic [1:0]  explode_step,
  output logic        exploding,
  output logic [15:0] score
);

  // One shared frame counter serves both the explosion steps and the respawn wait.
  localparam int CNT_MAX = (STEP_FRAMES > RESPAWN_FRAMES) ? STEP_FRAMES : RESPAWN_FRAMES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
  localparam logic [CW-1:0] RESP_LAST = CW'(RESPAWN_FRAMES - 1);

  localparam logic [1:0] ST_ALIVE   = 2'd0;
  localparam logic [1:0] ST_EXPLODE = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    step_reg, step_next;
  logic          boom_reg, boom_next;
  logic [15:0]   score_reg, score_next;
  logic          alive_reg, exploding_reg;

  // Rectangle edges widened to 11 bits so right/bottom edges never wrap.
  logic [10:0] bx_lo, bx_hi, by_lo, by_hi;
  logic [10:0] ex_lo, ex_hi, ey_lo, ey_hi;
  logic        hit_now;

  assign bx_lo = {1'b0, b_x};
  assign bx_hi = {1'b0, b_x} + 11'(BW);
  assign by_lo = {1'b0, b_y};
  assign by_hi = {1'b0, b_y} + 11'(BH);
  assign ex_lo = {1'b0, e_x};
  assign ex_hi = {1'b0, e_x} + 11'(EW);
  assign ey_lo = {1'b0, e_y};
  assign ey_hi = {1'b0, e_y} + 11'(EH);

  // Strict inequalities: rectangles that merely share an edge do not collide.
  assign hit_now = b_valid & (bx_lo < ex_hi) & (bx_hi > ex_lo) &
                   (by_lo < ey_hi) & (by_hi > ey_lo);

  // BCD ripple increment: each digit rolls 9 -> 0 and carries upward.
  logic [4:0]  carry;
  logic [15:0] score_inc;
  logic        score_sat;

  assign carry[0]  = 1'b1;
  assign score_sat = (score_reg == 16'h9999);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
    logic [3:0] digit;
    assign digit               = score_reg[gi*4 +: 4];
    assign carry[gi+1]         = carry[gi] & (digit == 4'd9);
    assign score_inc[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
  end

  // Next-state logic; everything advances only on frame ticks.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = step_reg;
    boom_next  = 1'b0;
    score_next = score_reg;
    case (state_reg)
      ST_ALIVE: begin
        if (frame_tick && hit_now) begin
          boom_next  = 1'b1;
          score_next = score_sat ? score_reg : score_inc;
          state_next = ST_EXPLODE;
          step_next  = 2'd0;
          cnt_next   = '0;
        end
      end
      ST_EXPLODE: begin
        if (frame_tick) begin
          if (cnt_reg == STEP_LAST) begin
            cnt_next = '0;
            if (step_reg == 2'd3) begin
              state_next = ST_DEAD;
              step_next  = 2'd0;
            end else begin
              step_next = step_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_DEAD: begin
        // The respawn tick itself is not judged; collisions resume next tick.
        if (frame_tick) begin
          if (cnt_reg == RESP_LAST) begin
            state_next = ST_ALIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = ST_ALIVE;
        cnt_next   = '0;
        step_next  = 2'd0;
      end
    endcase
  end

  // State, counters, score and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_ALIVE;
      cnt_reg       <= '0;
      step_reg      <= 2'd0;
      boom_reg      <= 1'b0;
      score_reg     <= 16'h0000;
      alive_reg     <= 1'b1;
      exploding_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      step_reg      <= step_next;
      boom_reg      <= boom_next;
      score_reg     <= score_next;
      alive_reg     <= (state_next == ST_ALIVE);
      exploding_reg <= (state_next == ST_EXPLODE);
    end
  end

  assign boom         = boom_reg;
  assign enemy_alive  = alive_reg;
  assign exploding    = exploding_reg;
  assign explode_step = step_reg;
  assign score        = score_reg;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus pushes the expected score of each
// boom into a queue, a monitor pops it whenever boom is seen. A second,
// fast-cycling instance covers BCD carries and saturation at 9999.
module tb_hit_judge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst, frame_tick, b_valid;
  logic [9:0]  b_x, b_y, e_x, e_y;
  logic        boom, enemy_alive, exploding;
  logic [1:0]  explode_step;
  logic [15:0] score;

  hit_judge dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .b_valid(b_valid),
    .b_x(b_x), .b_y(b_y), .e_x(e_x), .e_y(e_y),
    .boom(boom), .enemy_alive(enemy_alive), .explode_step(explode_step),
    .exploding(exploding), .score(score)
  );

  // Fast instance: one-frame steps and respawn, ticking every clock
  logic        rst_f, tick_f, bv_f;
  logic [9:0]  bx_f, by_f, ex_f, ey_f;
  logic        boom_f, alive_f, expl_f;
  logic [1:0]  step_f;
  logic [15:0] score_f;

  hit_judge #(.STEP_FRAMES(1), .RESPAWN_FRAMES(1)) dut_fast (
    .clk(clk), .rst(rst_f), .frame_tick(tick_f), .b_valid(bv_f),
    .b_x(bx_f), .b_y(by_f), .e_x(ex_f), .e_y(ey_f),
    .boom(boom_f), .enemy_alive(alive_f), .explode_step(step_f),
    .exploding(expl_f), .score(score_f)
  );

  int errors = 0;
  int checks = 0;
  int boom_cnt = 0;
  int fast_cnt = 0;
  int n_hits = 0;
  int saved;
  logic boom_prev = 1'b0;
  logic boom_f_prev = 1'b0;
  logic tick_at_edge = 1'b0;
  logic fast_done = 1'b0;
  logic [15:0] exp_front;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic expect_hit();
    if (n_hits < 9999) n_hits++;
    exp_q.push_back(to_bcd(n_hits));
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    #1;
  endtask

  task automatic set_pos(input logic [9:0] bx, input logic [9:0] by);
    b_x = bx; b_y = by; e_x = 10'd90; e_y = 10'd80;
  endtask

  task automatic hit_and_recover();
    b_valid = 1'b1;
    set_pos(10'd100, 10'd100);
    expect_hit();
    tick();
    b_valid = 1'b0;
    repeat (84) tick();
    check("respawned", enemy_alive, 1);
  endtask

  always @(posedge clk) tick_at_edge <= frame_tick;

  // Main monitor: every boom must match the oldest expectation
  always @(negedge clk) begin
    if (boom) begin
      boom_cnt++;
      check("boom_not_consecutive", boom_prev, 0);
      check("boom_after_tick", tick_at_edge, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_boom: got boom=1 score=%h, required no boom", score);
      end else begin
        exp_front = exp_q.pop_front();
        check("boom_score", score, exp_front);
      end
      $display("boom %0d: score=%h", boom_cnt, score);
    end
    boom_prev = boom;
  end

  // Fast monitor: BCD carry points and saturation
  always @(negedge clk) begin
    if (boom_f) begin
      fast_cnt++;
      if (boom_f_prev) begin
        checks++;
        errors++;
        $display("FAIL fast_boom_consecutive: got two adjacent booms, required gap");
      end
      case (fast_cnt)
        9:     check("fast_score_9", score_f, 16'h0009);
        10:    check("fast_score_10", score_f, 16'h0010);
        100:   check("fast_score_100", score_f, 16'h0100);
        1000:  check("fast_score_1000", score_f, 16'h1000);
        9999:  check("fast_score_9999", score_f, 16'h9999);
        10000: check("fast_sat_10000", score_f, 16'h9999);
        10001: check("fast_sat_10001", score_f, 16'h9999);
        default: ;
      endcase
    end
    boom_f_prev = boom_f;
  end

  // Fast instance stimulus: permanent overlap, tick every clock
  initial begin
    int c;
    rst_f = 1'b0; tick_f = 1'b0; bv_f = 1'b1;
    bx_f = 10'd100; by_f = 10'd100; ex_f = 10'd90; ey_f = 10'd80;
    repeat (3) @(negedge clk);
    rst_f = 1'b1;
    tick_f = 1'b1;
    c = 0;
    while (fast_cnt < 10001 && c < 70000) begin
      @(negedge clk);
      #1;
      c++;
    end
    tick_f = 1'b0;
    check("fast_boom_count", fast_cnt, 10001);
    check("fast_final_score", score_f, 16'h9999);
    fast_done = 1'b1;
  end

  // Main stimulus
  initial begin
    logic [9:0] edge_x[4];
    logic [9:0] edge_y[4];
    rst = 1'b0; frame_tick = 1'b0; b_valid = 1'b0;
    set_pos(10'd0, 10'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_boom", boom, 0);
    check("rst_alive", enemy_alive, 1);
    check("rst_exploding", exploding, 0);
    check("rst_step", explode_step, 0);
    check("rst_score", score, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Test 1 + 3: hit, explosion timeline, dead period with overlap held
    b_valid = 1'b1;
    set_pos(10'd100, 10'd100);
    expect_hit();
    tick();
    check("t1_boom_seen", boom_cnt, 1);
    check("t1_score", score, 16'h0001);
    check("t1_alive", enemy_alive, 0);
    check("t1_exploding", exploding, 1);
    check("t1_step", explode_step, 0);
    for (int k = 1; k <= 84; k++) begin
      tick();
      check($sformatf("t3_step_k%0d", k), explode_step, (k < 24) ? k / 6 : 0);
      check($sformatf("t3_expl_k%0d", k), exploding, (k < 24) ? 1 : 0);
      check($sformatf("t3_alive_k%0d", k), enemy_alive, (k >= 84) ? 1 : 0);
    end
    check("t3_no_extra_boom", boom_cnt, 1);

    // Test 2: edge contact on each side is not a hit
    edge_x[0] = 10'd138; edge_y[0] = 10'd100;
    edge_x[1] = 10'd86;  edge_y[1] = 10'd100;
    edge_x[2] = 10'd100; edge_y[2] = 10'd40;
    edge_x[3] = 10'd100; edge_y[3] = 10'd128;
    for (int i = 0; i < 4; i++) begin
      set_pos(edge_x[i], edge_y[i]);
      tick();
      check($sformatf("t2_edge%0d_boom", i), boom_cnt, 1);
      check($sformatf("t2_edge%0d_score", i), score, 16'h0001);
    end
    set_pos(10'd137, 10'd100);
    expect_hit();
    tick();
    check("t2_overlap_boom", boom_cnt, 2);
    check("t2_overlap_score", score, 16'h0002);
    b_valid = 1'b0;
    repeat (84) tick();
    check("t2_respawn", enemy_alive, 1);

    // Test 4: reach 9, then carry into tens
    while (n_hits < 9) hit_and_recover();
    check("t4_score_9", score, 16'h0009);
    hit_and_recover();
    check("t4_score_10", score, 16'h0010);

    // Test 5: overlap without tick, and tick without b_valid
    saved = boom_cnt;
    b_valid = 1'b1;
    set_pos(10'd100, 10'd100);
    repeat (1000) @(negedge clk);
    #1;
    check("t5_no_tick_no_boom", boom_cnt, saved);
    b_valid = 1'b0;
    tick();
    check("t5_invalid_no_boom", boom_cnt, saved);
    check("t5_still_alive", enemy_alive, 1);

    // Test 6: async reset mid-explosion at step 2
    b_valid = 1'b1;
    expect_hit();
    tick();
    repeat (12) tick();
    check("t6_step2", explode_step, 2);
    check("t6_exploding", exploding, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_boom", boom, 0);
    check("t6_rst_alive", enemy_alive, 1);
    check("t6_rst_exploding", exploding, 0);
    check("t6_rst_step", explode_step, 0);
    check("t6_rst_score", score, 16'h0000);
    n_hits = 0;
    @(negedge clk);
    rst = 1'b1;
    expect_hit();
    tick();
    check("t6_post_score", score, 16'h0001);
    check("t6_post_alive", enemy_alive, 0);
    b_valid = 1'b0;

    wait (fast_done);
    check("pending_booms", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
